// File: rtl/elastic_pipe_stage.sv
// Generic pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Payload is opaque; flush kills held entries and counts them in a saturating counter.
module elastic_pipe_stage #(
   parameter int DATA_W         = 32,
   parameter bit CLEAR_ON_FLUSH = 1'b1,
   parameter int KILL_CNT_W     = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [1:0]            occupancy,
   output logic [KILL_CNT_W-1:0] kill_cnt
);

   // Handshake: a beat moves when valid and ready are both high at the rising edge;
   // valid never waits on ready, and in_ready depends only on registered state.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_W-1:0]     main_q, main_nxt;
   logic [DATA_W-1:0]     skid_q, skid_nxt;
   logic [KILL_CNT_W-1:0] kill_q, kill_nxt;
   logic [KILL_CNT_W:0]   kill_sum;
   logic                  in_fire;
   logic                  out_fire;

   assign in_ready  = (state != ST_SKID);
   assign out_valid = (state != ST_EMPTY);
   assign out_data  = main_q;
   assign kill_cnt  = kill_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready & ~stall;

   always_comb begin
      occupancy = 2'd0;
      case (state)
         ST_FULL: occupancy = 2'd1;
         ST_SKID: occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // One spare bit absorbs the carry so saturation is a simple compare.
   assign kill_sum = {1'b0, kill_q} + (KILL_CNT_W+1)'(occupancy);

   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      kill_nxt  = kill_q;
      if (flush) begin
         state_nxt = ST_EMPTY;
         if (kill_sum > {1'b0, {KILL_CNT_W{1'b1}}})
            kill_nxt = {KILL_CNT_W{1'b1}};
         else
            kill_nxt = kill_sum[KILL_CNT_W-1:0];
         if (CLEAR_ON_FLUSH) begin
            main_nxt = '0;
            skid_nxt = '0;
         end
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt = ST_FULL;
                  main_nxt  = in_data;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire) begin
                  state_nxt = ST_SKID;
                  skid_nxt  = in_data;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  state_nxt = ST_FULL;
                  main_nxt  = skid_q;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_EMPTY;
         main_q <= '0;
         skid_q <= '0;
         kill_q <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
         kill_q <= kill_nxt;
      end
   end

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Directed and random checks for elastic_pipe_stage; a second instance with a 2-bit
// kill counter and data-holding flush shares the same stimulus.
module tb_elastic_pipe_stage;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       stall = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid;
   logic [7:0] out_data;
   logic [1:0] occupancy;
   logic [7:0] kill_cnt;
   logic       in_ready2, out_valid2;
   logic [7:0] out_data2;
   logic [1:0] occupancy2;
   logic [1:0] kill_cnt2;

   int         passed = 0;
   int         total = 0;
   int         exp_kill = 0;
   bit         sb_en = 1'b0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   elastic_pipe_stage #(.DATA_W(8), .CLEAR_ON_FLUSH(1'b1), .KILL_CNT_W(8)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .kill_cnt(kill_cnt)
   );

   elastic_pipe_stage #(.DATA_W(8), .CLEAR_ON_FLUSH(1'b0), .KILL_CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .occupancy(occupancy2), .kill_cnt(kill_cnt2)
   );

   // Scoreboard: sampled mid-cycle, where inputs and outputs are both settled.
   always @(negedge clk) begin
      if (sb_en && !reset && !flush) begin
         if (out_valid && out_ready && !stall) begin
            total++;
            if (exp_q.size() == 0)
               $display("FAIL sb_underflow: got 0x%02h with nothing expected", out_data);
            else begin
               if (out_data !== exp_q[0])
                  $display("FAIL sb_data: got 0x%02h exp 0x%02h", out_data, exp_q[0]);
               else
                  passed++;
               void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(in_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b exp 0", out_valid); else passed++;
      total++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got 0x%02h exp 0x00", out_data); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b exp 1", in_ready); else passed++;
      total++; if (occupancy !== 2'd0) $display("FAIL rst_occ: got %0d exp 0", occupancy); else passed++;
      total++; if (kill_cnt !== 8'd0) $display("FAIL rst_kill: got %0d exp 0", kill_cnt); else passed++;
   endtask

   task automatic test_streaming();
      logic [7:0] vals[3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      sb_en = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = vals[i];
         tick();
         total++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %0b exp 1", i, out_valid); else passed++;
         total++; if (out_data !== vals[i]) $display("FAIL stream_data[%0d]: got 0x%02h exp 0x%02h", i, out_data, vals[i]); else passed++;
         total++; if (occupancy !== 2'd1) $display("FAIL stream_occ[%0d]: got %0d exp 1", i, occupancy); else passed++;
      end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL stream_drained: got %0b exp 0", out_valid); else passed++;
      idle_inputs();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h0A; tick();
      in_data = 8'h0B; tick();
      in_valid = 1'b0; in_data = 8'h00;
      total++; if (occupancy !== 2'd2) $display("FAIL bp_occ: got %0d exp 2", occupancy); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b exp 0", in_ready); else passed++;
      tick();
      total++; if (out_data !== 8'h0A) $display("FAIL bp_hold: got 0x%02h exp 0x0a", out_data); else passed++;
      out_ready = 1'b1;
      tick();
      total++; if (out_data !== 8'h0B) $display("FAIL bp_second: got 0x%02h exp 0x0b", out_data); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %0b exp 1", in_ready); else passed++;
      tick();
      total++; if (occupancy !== 2'd0) $display("FAIL bp_empty: got %0d exp 0", occupancy); else passed++;
      idle_inputs();
   endtask

   task automatic test_stall();
      in_valid = 1'b1; in_data = 8'h05; tick();
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %0b exp 1", i, out_valid); else passed++;
         total++; if (out_data !== 8'h05) $display("FAIL stall_data[%0d]: got 0x%02h exp 0x05", i, out_data); else passed++;
      end
      stall = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL stall_release: got %0b exp 0", out_valid); else passed++;
      idle_inputs();
   endtask

   task automatic test_flush();
      sb_en = 1'b0; exp_q.delete();
      in_valid = 1'b1; in_data = 8'h44; tick();
      in_data = 8'h55; tick();
      in_data = 8'h77; flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      exp_kill = 2;
      total++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d exp 0", occupancy); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b exp 0", out_valid); else passed++;
      total++; if (kill_cnt !== 8'(exp_kill)) $display("FAIL flush_kill: got %0d exp %0d", kill_cnt, exp_kill); else passed++;
      total++; if (out_data !== 8'h00) $display("FAIL flush_clear: got 0x%02h exp 0x00", out_data); else passed++;
      total++; if (out_data2 !== 8'h44) $display("FAIL flush_hold_data: got 0x%02h exp 0x44", out_data2); else passed++;
      out_ready = 1'b1;
      repeat (2) begin
         tick();
         total++; if (out_valid !== 1'b0) $display("FAIL flush_no_emit: got %0b exp 0", out_valid); else passed++;
      end
      // Flush in EMPTY with an accepted-looking beat: nothing counted, nothing stored.
      in_valid = 1'b1; in_data = 8'h66; flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (occupancy !== 2'd0) $display("FAIL flush_empty_occ: got %0d exp 0", occupancy); else passed++;
      total++; if (kill_cnt !== 8'(exp_kill)) $display("FAIL flush_empty_kill: got %0d exp %0d", kill_cnt, exp_kill); else passed++;
      // Flush beats stall while FULL.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h12; tick();
      in_valid = 1'b0; out_ready = 1'b1; stall = 1'b1; flush = 1'b1; tick();
      exp_kill = 3;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_stall_valid: got %0b exp 0", out_valid); else passed++;
      total++; if (kill_cnt !== 8'(exp_kill)) $display("FAIL flush_stall_kill: got %0d exp %0d", kill_cnt, exp_kill); else passed++;
      total++; if (kill_cnt2 !== 2'd3) $display("FAIL flush_stall_kill2: got %0d exp 3", kill_cnt2); else passed++;
      idle_inputs();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h80 + i); tick();
         in_data = 8'(8'h90 + i); tick();
         in_valid = 1'b0; flush = 1'b1; tick();
         flush = 1'b0;
         exp_kill = exp_kill + 2;
         total++; if (kill_cnt2 !== 2'd3) $display("FAIL sat_kill2[%0d]: got %0d exp 3", i, kill_cnt2); else passed++;
         total++; if (kill_cnt !== 8'(exp_kill)) $display("FAIL sat_kill8[%0d]: got %0d exp %0d", i, kill_cnt, exp_kill); else passed++;
      end
      idle_inputs();
   endtask

   task automatic test_reset_midtransfer();
      in_valid = 1'b1; in_data = 8'hC1; tick();
      in_data = 8'hC2; tick();
      in_valid = 1'b0;
      reset = 1'b1; #2;
      total++; if (occupancy !== 2'd0) $display("FAIL midrst_occ: got %0d exp 0", occupancy); else passed++;
      total++; if (kill_cnt !== 8'd0) $display("FAIL midrst_kill: got %0d exp 0", kill_cnt); else passed++;
      tick();
      reset = 1'b0;
      idle_inputs();
   endtask

   task automatic test_random();
      sb_en = 1'b1; exp_q.delete();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_data   = 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 3) != 0);
         stall     = ($urandom_range(0, 7) == 0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1; stall = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      tick();
      total++; if (exp_q.size() != 0) $display("FAIL rand_drain: %0d entries left exp 0", exp_q.size()); else passed++;
      total++; if (occupancy !== 2'd0) $display("FAIL rand_occ: got %0d exp 0", occupancy); else passed++;
      sb_en = 1'b0;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_stall();
      test_flush();
      test_saturation();
      test_reset_midtransfer();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
